alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single integer ALU between two requesters: port 0 is the execute stage and port 1 is the branch-compare unit. Each requester uses a valid/ready request handshake and a valid/ready response handshake. The arbiter grants one request at a time and drives the ALU from a registered issue stage. It captures the ALU result and flag, then holds the response until the owning requester accepts it.

## Interface
- `XLEN`, 32: operand/result width.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `req_valid_i` in 2: request valid, bit n = requester n.
- `req_ready_o` out 2: request accepted this cycle, one-hot or zero.
- `req_opa_i` in 2*XLEN: operand A, slice n = requester n.
- `req_opb_i` in 2*XLEN: operand B, per requester.
- `req_aluctrl_i` in 8: 4-bit ALU op per requester.
- `req_flagsel_i` in 6: 3-bit flag select per requester.
- `alu_opa_o`, `alu_opb_o` out XLEN: operands to ALU.
- `alu_ctrl_o` out 4, `alu_flagsel_o` out 3: ALU controls.
- `alu_result_i` in XLEN, `alu_flag_i` in 1: ALU combinational outputs.
- `rsp_valid_o` out 2: response valid, one-hot to owner.
- `rsp_ready_i` in 2: response accepted by requester n.
- `rsp_result_o` out XLEN, `rsp_flag_o` out 1: response payload, shared by both requesters.
- `busy_o` out 1: high in any state except IDLE.

## Operation
- FSM states:
  - IDLE → ISSUE on any `req_valid_i`.
  - ISSUE → RESP unconditionally.
  - RESP → IDLE when `rsp_valid_o[g] & rsp_ready_i[g]`.
- IDLE:
  - The arbiter picks the grant g and sets `req_ready_o[g]`=1 combinationally.
  - On the clock edge it latches g, operands, op and flagsel into issue registers.
  - `req_ready_o` is 0 in ISSUE and RESP.
- Grant policy is round-robin. `last_g` flips on every grant.
  - If both requesters are valid, the one that is not `last_g` wins.
  - If only one is valid, it wins regardless of `last_g`.
  - `last_g` resets to 1, so requester 0 wins the first contention.
- ISSUE:
  - `alu_*_o` are driven from the issue registers.
  - `alu_result_i` is captured at the end of the cycle.
  - `rsp_flag` captures `alu_flag_i` only when the op is SUB (0001); otherwise it captures 0.
  - Flagsel codes 110/111 capture 0.
- RESP:
  - `rsp_valid_o[g]`=1, and the payload is stable until the handshake completes.
  - `rsp_ready_i` on the non-owner bit is ignored.
- Outside ISSUE, `alu_*_o` hold their last issued values; no toggling is required.
- Request payload must be stable while valid and not ready; the arbiter does not check this.
- Reset (async, any state):
  - State returns to IDLE and `last_g` to 1.
  - `req_ready_o`, `rsp_valid_o`, `busy_o`, `rsp_result_o`, `rsp_flag_o` and all `alu_*_o` go to 0.
  - An in-flight op is dropped and no response is issued for it.

## Timing
- Request accepted in cycle N (IDLE, ready=1).
- ALU is driven during N+1 (ISSUE).
- `rsp_valid_o` rises in N+2.
- If `rsp_ready_i` is high in N+2, the arbiter is back in IDLE at N+3 and can accept again in N+3.
- Peak throughput is 1 op / 3 cycles.
- Backpressure extends RESP indefinitely with no loss.
- `req_ready_o` depends combinationally on `req_valid_i` and state. It has no combinational path from `rsp_ready_i`.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - When defined, requester 0 (execute) always wins contention and `last_g` is not implemented.
  - When undefined, the round-robin policy above applies.
- Handshake and latency are identical in both builds.

## Structure
- Package `alu_pkg` holds:
  - ALU op constants: ADD 0000, SUB 0001, SLL 0010, XOR 0011, SRL 0100, SRA 0101, OR 0110, AND 0111, LUI 1000.
  - Flagsel constants: EQ 000, NE 001, LT 010, GE 011, LTU 100, GEU 101.
  - FSM state typedef.
- Sub-module `rr_arbiter2` contains the two-input grant logic and the `last_g` register, including the fixed-priority variant.

## Test plan
- Single request: req 0 ADD A=5, B=7, `rsp_ready`=1 → `rsp_valid_o`=01 at N+2, result 12, flag 0.
- Contention after reset: both valid; req 0 SUB 3,3 flagsel EQ; req 1 SUB 2,9 flagsel LTU.
  - Req 0 is served first with flag 1.
  - Req 1 is then served with flag 1 and result 0xFFFFFFF9.
- Backpressure: `rsp_ready_i`=0 for 5 cycles → `rsp_valid_o` and payload held; `req_ready_o` stays 00 and new requests wait; completes on ready.
- Flag masking: req 1 XOR with flagsel NE and model `alu_flag_i`=1 → `rsp_flag_o`=0.
- Round-robin fairness: both requesters valid continuously for 6 grants → order 0,1,0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN` → all grants go to 0.
- Reset mid-op: assert `rst_i` in ISSUE → all outputs 0 immediately, no response issued; the next request is granted normally.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU op and flag-select codes, arbiter FSM states, flag capture rule
package alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_SLL = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;
  localparam logic [3:0] ALU_OR  = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;
  localparam logic [2:0] FLAG_EQ  = 3'b000;
  localparam logic [2:0] FLAG_NE  = 3'b001;
  localparam logic [2:0] FLAG_LT  = 3'b010;
  localparam logic [2:0] FLAG_GE  = 3'b011;
  localparam logic [2:0] FLAG_LTU = 3'b100;
  localparam logic [2:0] FLAG_GEU = 3'b101;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  // The ALU flag is only meaningful for a compare (SUB) with a defined select.
  function automatic logic flag_keep(input logic [3:0] op, input logic [2:0] fsel);
    return op == ALU_SUB && fsel <= FLAG_GEU;
  endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two-requester request/response bus of alu_arbiter
// master: requester side (drives req_*_i, rsp_ready_i); slave: arbiter side.
// Slices: bit n / slice n of each vector belongs to requester n.
interface alu_arbiter_if #(parameter int XLEN = 32);
  logic [1:0]        req_valid_i, req_ready_o;
  logic [2*XLEN-1:0] req_opa_i, req_opb_i;
  logic [7:0]        req_aluctrl_i;
  logic [5:0]        req_flagsel_i;
  logic [1:0]        rsp_valid_o, rsp_ready_i;
  logic [XLEN-1:0]   rsp_result_o;
  logic              rsp_flag_o;
  modport master(output req_valid_i, req_opa_i, req_opb_i, req_aluctrl_i, req_flagsel_i, rsp_ready_i,
                 input req_ready_o, rsp_valid_o, rsp_result_o, rsp_flag_o);
  modport slave(input req_valid_i, req_opa_i, req_opb_i, req_aluctrl_i, req_flagsel_i, rsp_ready_i,
                output req_ready_o, rsp_valid_o, rsp_result_o, rsp_flag_o);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input grant logic with round-robin last_g register
// Ports: clk_i/rst_i (async, active-high), en_i grant allowed, req_i requests,
//        gnt_o one-hot grant (zero when not enabled), gnt_idx_o winning index.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins, no last_g state.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_i;
  assign gnt_idx_o = ~req_i[0];
`else
  logic last_g_q, last_g_d;
  assign gnt_idx_o = &req_i ? ~last_g_q : req_i[1];
  // last_g toggles on every grant, independent of which requester won.
  always_comb last_g_d = (en_i && |req_i) ? ~last_g_q : last_g_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) last_g_q <= 1'b1;
    else last_g_q <= last_g_d;
`endif
  assign gnt_o = (en_i && |req_i) ? (gnt_idx_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between execute (0) and branch-compare (1) requesters
// Ports: clk_i/rst_i (async, active-high), bus (alu_arbiter_if.slave request and
//        response handshakes), alu_* operands/controls out and result/flag in,
//        busy_o high outside IDLE.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority in rr_arbiter2.
module alu_arbiter import alu_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk_i,
  input  logic            rst_i,
  alu_arbiter_if.slave    bus,
  output logic [XLEN-1:0] alu_opa_o,
  output logic [XLEN-1:0] alu_opb_o,
  output logic [3:0]      alu_ctrl_o,
  output logic [2:0]      alu_flagsel_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_flag_i,
  output logic            busy_o
);
  state_t          state_q, state_d;
  logic            g_q, g_d, rsp_flag_q, rsp_flag_d, gnt_idx, en, take;
  logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic [2:0]      fsel_q, fsel_d;
  // Gating with rst_i keeps req_ready_o low while reset is held.
  assign en = state_q == IDLE && !rst_i;
  assign take = en && |bus.req_valid_i;
  rr_arbiter2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (en),
    .req_i     (bus.req_valid_i),
    .gnt_o     (bus.req_ready_o),
    .gnt_idx_o (gnt_idx)
  );
  always_comb begin
    state_d    = take ? ISSUE : state_q == ISSUE ? RESP :
                 (state_q == RESP && bus.rsp_ready_i[g_q]) ? IDLE : state_q;
    g_d        = take ? gnt_idx : g_q;
    opa_d      = take ? (gnt_idx ? bus.req_opa_i[2*XLEN-1:XLEN] : bus.req_opa_i[XLEN-1:0]) : opa_q;
    opb_d      = take ? (gnt_idx ? bus.req_opb_i[2*XLEN-1:XLEN] : bus.req_opb_i[XLEN-1:0]) : opb_q;
    ctrl_d     = take ? (gnt_idx ? bus.req_aluctrl_i[7:4] : bus.req_aluctrl_i[3:0]) : ctrl_q;
    fsel_d     = take ? (gnt_idx ? bus.req_flagsel_i[5:3] : bus.req_flagsel_i[2:0]) : fsel_q;
    res_d      = state_q == ISSUE ? alu_result_i : res_q;
    rsp_flag_d = state_q == ISSUE ? flag_keep(ctrl_q, fsel_q) & alu_flag_i : rsp_flag_q;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q    <= IDLE;
      g_q        <= 1'b0;
      opa_q      <= '0;
      opb_q      <= '0;
      ctrl_q     <= '0;
      fsel_q     <= '0;
      res_q      <= '0;
      rsp_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      g_q        <= g_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      ctrl_q     <= ctrl_d;
      fsel_q     <= fsel_d;
      res_q      <= res_d;
      rsp_flag_q <= rsp_flag_d;
    end
  assign alu_opa_o        = opa_q;
  assign alu_opb_o        = opb_q;
  assign alu_ctrl_o       = ctrl_q;
  assign alu_flagsel_o    = fsel_q;
  assign bus.rsp_valid_o  = state_q == RESP ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result_o = res_q;
  assign bus.rsp_flag_o   = rsp_flag_q;
  assign busy_o           = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with an ALU model and reference scoreboard
module tb_alu_arbiter;
  import alu_pkg::*;
  localparam int XLEN = 32;
  typedef struct {bit g; logic [XLEN-1:0] r; logic f;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [XLEN-1:0] alu_opa, alu_opb, alu_result;
  logic [3:0] alu_ctrl;
  logic [2:0] alu_fsel;
  logic alu_flag, busy;
  logic flag_force = 1'b0;
  int total = 0, bad = 0;
  bit last_g = 1'b1;
  logic [3:0] op_r [2];
  logic [2:0] fs_r [2];
  logic [XLEN-1:0] a_r [2], b_r [2];
  always #5 clk = ~clk;
  alu_arbiter_if #(.XLEN(XLEN)) bus ();
  alu_arbiter #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .alu_opa_o(alu_opa), .alu_opb_o(alu_opb), .alu_ctrl_o(alu_ctrl), .alu_flagsel_o(alu_fsel),
    .alu_result_i(alu_result), .alu_flag_i(alu_flag), .busy_o(busy)
  );
  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_SLL: return a << b[4:0];
      ALU_XOR: return a ^ b;
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_LUI: return b;
      default: return '0;
    endcase
  endfunction
  function automatic logic cmp_f(input logic [2:0] fs, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    case (fs)
      FLAG_EQ:  return a == b;
      FLAG_NE:  return a != b;
      FLAG_LT:  return $signed(a) < $signed(b);
      FLAG_GE:  return $signed(a) >= $signed(b);
      FLAG_LTU: return a < b;
      FLAG_GEU: return a >= b;
      default:  return 1'b0;
    endcase
  endfunction
  assign alu_result = alu_f(alu_ctrl, alu_opa, alu_opb);
  assign alu_flag = flag_force | cmp_f(alu_fsel, alu_opa, alu_opb);
  // Reference grant rule: contention goes to the requester that is not last_g,
  // a lone requester always wins; fixed build always favours requester 0.
  function automatic bit model_pick(input logic [1:0] v, input bit last);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return !v[0];
`else
    return v == 2'b11 ? !last : v[1];
`endif
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int n, input logic [3:0] op, input logic [2:0] fs, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op_r[n] = op; fs_r[n] = fs; a_r[n] = a; b_r[n] = b;
    bus.req_aluctrl_i[n*4 +: 4] = op;
    bus.req_flagsel_i[n*3 +: 3] = fs;
    bus.req_opa_i[n*XLEN +: XLEN] = a;
    bus.req_opb_i[n*XLEN +: XLEN] = b;
  endtask
  task automatic rand_req(input int n);
    set_req(n, 4'($urandom_range(0, 8)), 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom);
  endtask
  task automatic do_reset();
    rst = 1'b1; bus.req_valid_i = 2'b00; bus.rsp_ready_i = 2'b00; flag_force = 1'b0; last_g = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
  endtask
  task automatic test_reset();
    rst = 1'b1; bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b11;
    set_req(0, ALU_ADD, FLAG_EQ, 1, 2); set_req(1, ALU_SUB, FLAG_NE, 3, 4);
    #2;
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready_o); end
    total++; if (bus.rsp_valid_o !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({bus.rsp_result_o, bus.rsp_flag_o} !== '0) begin bad++; $display("FAIL reset_rsp_payload got=%h/%b exp=0/0", bus.rsp_result_o, bus.rsp_flag_o); end
    total++; if ({alu_opa, alu_opb, alu_ctrl, alu_fsel} !== '0) begin bad++; $display("FAIL reset_alu_out got=%h %h %h %h exp=0", alu_opa, alu_opb, alu_ctrl, alu_fsel); end
    do_reset();
  endtask
  task automatic test_single();
    set_req(0, ALU_ADD, FLAG_EQ, 5, 7); bus.req_valid_i = 2'b01; bus.rsp_ready_i = 2'b11;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL single_ready got=%b exp=01", bus.req_ready_o); end
    last_g = !last_g;
    cyc();
    total++; if (busy !== 1'b1 || bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL single_issue busy/ready got=%b/%b exp=1/00", busy, bus.req_ready_o); end
    total++; if (alu_opa !== 5 || alu_opb !== 7 || alu_ctrl !== ALU_ADD) begin bad++; $display("FAIL single_alu_drive got=%0d %0d %h exp=5 7 0", alu_opa, alu_opb, alu_ctrl); end
    bus.req_valid_i = 2'b00;
    cyc();
    total++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 12 || bus.rsp_flag_o !== 1'b0) begin bad++; $display("FAIL single_rsp got=%b %0d %b exp=01 12 0", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_flag_o); end
    cyc();
    total++; if (busy !== 1'b0 || bus.rsp_valid_o !== 2'b00) begin bad++; $display("FAIL single_done busy/rsp got=%b/%b exp=0/00", busy, bus.rsp_valid_o); end
  endtask
  task automatic test_contention();
    bit g;
    do_reset();
    set_req(0, ALU_SUB, FLAG_EQ, 3, 3); set_req(1, ALU_SUB, FLAG_LTU, 2, 9);
    bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b11;
    #1;
    g = model_pick(2'b11, last_g); last_g = !last_g;
    total++; if (bus.req_ready_o !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_first_grant got=%b exp=%0d", bus.req_ready_o, g); end
    cyc();
    bus.req_valid_i = 2'b10;
    cyc();
    total++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== 0 || bus.rsp_flag_o !== 1'b1) begin bad++; $display("FAIL cont_rsp0 got=%b %h %b exp=01 0 1", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_flag_o); end
    cyc();
    g = model_pick(2'b10, last_g); last_g = !last_g;
    total++; if (bus.req_ready_o !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_second_grant got=%b exp=%0d", bus.req_ready_o, g); end
    cyc();
    bus.req_valid_i = 2'b00;
    cyc();
    total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== 32'hFFFF_FFF9 || bus.rsp_flag_o !== 1'b1) begin bad++; $display("FAIL cont_rsp1 got=%b %h %b exp=10 fffffff9 1", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_flag_o); end
    cyc();
  endtask
  task automatic test_backpressure();
    logic [XLEN-1:0] a = $urandom, b = $urandom, c = $urandom, d = $urandom;
    bus.rsp_ready_i = 2'b00;
    set_req(1, ALU_ADD, FLAG_EQ, a, b); bus.req_valid_i = 2'b10;
    #1;
    total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL bp_grant got=%b exp=10", bus.req_ready_o); end
    last_g = !last_g;
    cyc();
    set_req(0, ALU_OR, FLAG_EQ, c, d); bus.req_valid_i = 2'b01; bus.rsp_ready_i = 2'b01;
    cyc();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== a + b || bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_hold_%0d got=%b %h %b exp=10 %h 00", i, bus.rsp_valid_o, bus.rsp_result_o, bus.req_ready_o, a + b); end
      cyc();
    end
    bus.rsp_ready_i = 2'b10;
    #1;
    total++; if (bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL bp_ready_path got=%b exp=00", bus.req_ready_o); end
    cyc();
    total++; if (bus.req_ready_o !== 2'b01 || bus.rsp_valid_o !== 2'b00) begin bad++; $display("FAIL bp_release got=%b/%b exp=01/00", bus.req_ready_o, bus.rsp_valid_o); end
    last_g = !last_g;
    cyc();
    bus.req_valid_i = 2'b00; bus.rsp_ready_i = 2'b11;
    cyc();
    total++; if (bus.rsp_valid_o !== 2'b01 || bus.rsp_result_o !== (c | d)) begin bad++; $display("FAIL bp_next_rsp got=%b %h exp=01 %h", bus.rsp_valid_o, bus.rsp_result_o, c | d); end
    cyc();
  endtask
  task automatic test_flag_mask();
    logic [3:0] ops [3] = '{ALU_XOR, ALU_SUB, ALU_SUB};
    logic [2:0] fss [3] = '{FLAG_NE, 3'b110, FLAG_EQ};
    int rq [3] = '{1, 0, 1};
    logic ef [3] = '{1'b0, 1'b0, 1'b1};
    logic [XLEN-1:0] a, b;
    flag_force = 1'b1; bus.rsp_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom;
      set_req(rq[i], ops[i], fss[i], a, b); bus.req_valid_i = rq[i] == 1 ? 2'b10 : 2'b01;
      #1;
      total++; if (bus.req_ready_o !== bus.req_valid_i) begin bad++; $display("FAIL mask_grant_%0d got=%b exp=%b", i, bus.req_ready_o, bus.req_valid_i); end
      last_g = !last_g;
      cyc();
      bus.req_valid_i = 2'b00;
      cyc();
      total++; if (bus.rsp_flag_o !== ef[i] || bus.rsp_result_o !== alu_f(ops[i], a, b)) begin bad++; $display("FAIL mask_rsp_%0d got=%b %h exp=%b %h", i, bus.rsp_flag_o, bus.rsp_result_o, ef[i], alu_f(ops[i], a, b)); end
      cyc();
    end
    flag_force = 1'b0;
  endtask
  task automatic test_fairness();
    exp_t q [$];
    exp_t e;
    int grants = 0;
    int refresh;
    bit g;
    do_reset();
    rand_req(0); rand_req(1); bus.req_valid_i = 2'b11; bus.rsp_ready_i = 2'b11;
    for (int c = 0; c < 80 && (grants < 6 || q.size() > 0); c++) begin
      refresh = -1;
      #1;
      if (bus.rsp_valid_o !== 2'b00) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL fair_unexpected_rsp got=%b exp=none", bus.rsp_valid_o); end
        else begin
          e = q.pop_front();
          if (bus.rsp_valid_o !== (e.g ? 2'b10 : 2'b01) || bus.rsp_result_o !== e.r || bus.rsp_flag_o !== e.f) begin bad++; $display("FAIL fair_rsp got=%b %h %b exp=%0d %h %b", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_flag_o, e.g, e.r, e.f); end
        end
      end
      if (bus.req_valid_i != 2'b00 && busy === 1'b0) begin
        g = model_pick(bus.req_valid_i, last_g); last_g = !last_g;
        total++; if (bus.req_ready_o !== (g ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fair_grant_%0d got=%b exp=%0d", grants, bus.req_ready_o, g); end
        q.push_back('{g, alu_f(op_r[g], a_r[g], b_r[g]), (op_r[g] == ALU_SUB && fs_r[g] < 3'd6) ? cmp_f(fs_r[g], a_r[g], b_r[g]) : 1'b0});
        grants++;
        refresh = g;
      end
      cyc();
      if (refresh >= 0) begin
        if (grants >= 6) bus.req_valid_i = 2'b00;
        else rand_req(refresh);
      end
    end
    total++; if (grants != 6 || q.size() != 0) begin bad++; $display("FAIL fair_timeout grants=%0d pending=%0d exp=6/0", grants, q.size()); end
  endtask
  task automatic test_reset_mid();
    logic [XLEN-1:0] a = $urandom, b = $urandom;
    bus.rsp_ready_i = 2'b11;
    set_req(0, ALU_ADD, FLAG_EQ, a, b); bus.req_valid_i = 2'b01;
    #1;
    total++; if (bus.req_ready_o !== 2'b01) begin bad++; $display("FAIL rmid_grant got=%b exp=01", bus.req_ready_o); end
    cyc();
    bus.req_valid_i = 2'b00;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || bus.rsp_valid_o !== 2'b00 || bus.req_ready_o !== 2'b00) begin bad++; $display("FAIL rmid_ctrl got=%b %b %b exp=0 00 00", busy, bus.rsp_valid_o, bus.req_ready_o); end
    total++; if ({alu_opa, alu_opb, alu_ctrl, alu_fsel, bus.rsp_result_o, bus.rsp_flag_o} !== '0) begin bad++; $display("FAIL rmid_data got=%h %h %h %h %h exp=0", alu_opa, alu_opb, alu_ctrl, alu_fsel, bus.rsp_result_o); end
    last_g = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++; if (bus.rsp_valid_o !== 2'b00) begin bad++; $display("FAIL rmid_no_rsp_%0d got=%b exp=00", i, bus.rsp_valid_o); end
    end
    a = $urandom; b = $urandom;
    set_req(1, ALU_SUB, FLAG_LT, a, b); bus.req_valid_i = 2'b10;
    #1;
    total++; if (bus.req_ready_o !== 2'b10) begin bad++; $display("FAIL rmid_next_grant got=%b exp=10", bus.req_ready_o); end
    last_g = !last_g;
    cyc();
    bus.req_valid_i = 2'b00;
    cyc();
    total++; if (bus.rsp_valid_o !== 2'b10 || bus.rsp_result_o !== a - b || bus.rsp_flag_o !== ($signed(a) < $signed(b))) begin bad++; $display("FAIL rmid_next_rsp got=%b %h %b exp=10 %h %b", bus.rsp_valid_o, bus.rsp_result_o, bus.rsp_flag_o, a - b, $signed(a) < $signed(b)); end
    cyc();
  endtask
  initial begin
    bus.req_valid_i = 2'b00; bus.rsp_ready_i = 2'b00;
    bus.req_opa_i = '0; bus.req_opb_i = '0; bus.req_aluctrl_i = '0; bus.req_flagsel_i = '0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flag_mask();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
